// File: rtl/capture_pkg.sv
`default_nettype none
// ============================================================================
// Module      : capture_pkg
// Description : Shared types and constants for the capture engine: FSM state
//               encoding, trigger-mode encodings, timeout terminal count and
//               the trigger-edge helper.
// Revision    : 1.0 - initial release
// ============================================================================
package capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic [1:0]  c_TRIG_ANY  = 2'b00;
    localparam logic [1:0]  c_TRIG_RISE = 2'b01;
    localparam logic [1:0]  c_TRIG_FALL = 2'b10;
    localparam logic [1:0]  c_TRIG_IMM  = 2'b11;

    localparam logic [15:0] c_TIMEOUT   = 16'hFFFF;

    // Edge test between the previous and current sample of the trigger channel
    function automatic logic trig_hit(input logic [1:0] mode,
                                      input logic       prev,
                                      input logic       cur);
        logic hit;
        case (mode)
            c_TRIG_ANY:  hit = (cur != prev);
            c_TRIG_RISE: hit = cur & ~prev;
            c_TRIG_FALL: hit = ~cur & prev;
            default:     hit = 1'b1;
        endcase
        return hit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/capture_ram.sv
`default_nettype none
// ============================================================================
// Module      : capture_ram
// Description : DEPTH x WIDTH sample memory, one write port and one registered
//               read port. Out-of-range or suppressed reads return zero.
// Revision    : 1.0 - initial release
// ============================================================================
module capture_ram #(
    parameter int DEPTH = 60,
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             arstn,
    input  logic             i_we,
    input  logic [5:0]       i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [5:0]       i_raddr,
    input  logic             i_rzero,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Sample storage; contents are not reset
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read, forced to zero when suppressed or out of range
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_rdata <= '0;
        end else if (i_rzero || (int'(i_raddr) >= DEPTH)) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/capture_engine.sv
`default_nettype none
// ============================================================================
// Module      : capture_engine
// Description : Logic-analyser style capture. Probes are synchronised to clk,
//               logic_in[0] rising edges mark sample events, samples are held
//               in a circular buffer around a trigger and read back oldest
//               first once the capture is done.
//               Optional: CAPTURE_TIMEOUT_EN forces a trigger after 0xFFFF
//               clk cycles in ARMED and flags it on timed_out.
// Revision    : 1.0 - initial release
// ============================================================================
module capture_engine
    import capture_pkg::*;
#(
    parameter int CHANNELS = 5,
    parameter int DEPTH    = 60,
    parameter int PRETRIG  = 3
) (
    input  logic                clk,
    input  logic                arstn,
    input  logic [CHANNELS:0]   logic_in,
    input  logic                start,
    input  logic                abort,
    input  logic [2:0]          trig_chan,
    input  logic [1:0]          trig_mode,
    input  logic [5:0]          rd_addr,
    output logic [CHANNELS-1:0] rd_data,
    output logic                busy,
    output logic                done,
    output logic                timed_out
);

    localparam logic [5:0] c_LAST    = 6'(DEPTH - 1);
    localparam logic [5:0] c_PRE     = 6'(PRETRIG);
    localparam logic [5:0] c_POSTLEN = 6'(DEPTH - PRETRIG - 1);
    localparam logic [5:0] c_WRAP    = 6'(DEPTH - PRETRIG);
    localparam logic [6:0] c_DEPTH7  = 7'(DEPTH);

    state_t              r_state;
    logic [CHANNELS:0]   r_sync1;
    logic [CHANNELS:0]   r_sync2;
    logic                r_sclk_q;
    logic [5:0]          r_wr_ptr;
    logic [5:0]          r_trig_ptr;
    logic [5:0]          r_count;
    logic                r_last;
    logic                r_busy;
    logic                r_done;

    logic                w_ev;
    logic [CHANNELS-1:0] w_sdata;
    logic                w_cur;
    logic                w_we;
    logic                w_natural;
    logic                w_force;
    logic                w_fire;
    logic                w_start_ok;
    logic [5:0]          w_next_ptr;
    logic [5:0]          w_oldest;
    logic [6:0]          w_sum;
    logic [5:0]          w_raddr;
    logic                w_rzero;

    // Two-flop synchroniser on every probe plus a delayed copy of the sample clock
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_sync1  <= '0;
            r_sync2  <= '0;
            r_sclk_q <= 1'b0;
        end else begin
            r_sync1  <= logic_in;
            r_sync2  <= r_sync1;
            r_sclk_q <= r_sync2[0];
        end
    end

    // A rise that appears after reset release lands in IDLE and writes nothing
    assign w_ev    = r_sync2[0] & ~r_sclk_q;
    assign w_sdata = r_sync2[CHANNELS:1];

    // Trigger channel select; indices beyond the last channel fall back to 0
    always_comb begin
        w_cur = w_sdata[0];
        for (int i = 1; i < CHANNELS; i++) begin
            if (int'(trig_chan) == i) begin
                w_cur = w_sdata[i];
            end
        end
    end

    assign w_we       = w_ev && ((r_state == ST_PRE) || (r_state == ST_ARMED) ||
                                 (r_state == ST_POST));
    assign w_natural  = trig_hit(trig_mode, r_last, w_cur);
    assign w_fire     = (r_state == ST_ARMED) && w_ev && (w_natural || w_force);
    assign w_start_ok = start && !abort && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_next_ptr = (r_wr_ptr == c_LAST) ? 6'd0 : r_wr_ptr + 6'd1;

    // Capture sequencing: pointers, counters, trigger position and status flags
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_state    <= ST_IDLE;
            r_wr_ptr   <= '0;
            r_trig_ptr <= '0;
            r_count    <= '0;
            r_last     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            if (w_we) begin
                r_wr_ptr <= w_next_ptr;
                r_last   <= w_cur;
            end
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state  <= (PRETRIG == 0) ? ST_ARMED : ST_PRE;
                        r_wr_ptr <= '0;
                        r_count  <= '0;
                        r_last   <= 1'b0;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                    end
                end
                ST_PRE: begin
                    if (w_ev) begin
                        r_count <= r_count + 6'd1;
                        if (r_count + 6'd1 == c_PRE) begin
                            r_state <= ST_ARMED;
                        end
                    end
                end
                ST_ARMED: begin
                    if (w_fire) begin
                        r_trig_ptr <= r_wr_ptr;
                        r_count    <= '0;
                        if (c_POSTLEN == 6'd0) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (w_ev) begin
                        r_count <= r_count + 6'd1;
                        if (r_count + 6'd1 == c_POSTLEN) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

`ifdef CAPTURE_TIMEOUT_EN
    logic [15:0] r_tmo_cnt;
    logic        r_timed_out;

    // ARMED dwell counter (saturating) and forced-trigger flag
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            r_tmo_cnt   <= '0;
            r_timed_out <= 1'b0;
        end else begin
            if (abort || (r_state != ST_ARMED)) begin
                r_tmo_cnt <= '0;
            end else if (r_tmo_cnt != c_TIMEOUT) begin
                r_tmo_cnt <= r_tmo_cnt + 16'd1;
            end
            if (w_start_ok) begin
                r_timed_out <= 1'b0;
            end else if (!abort && w_fire && !w_natural) begin
                r_timed_out <= 1'b1;
            end
        end
    end

    assign w_force   = (r_tmo_cnt == c_TIMEOUT);
    assign timed_out = r_timed_out;
`else
    assign w_force   = 1'b0;
    assign timed_out = 1'b0;
`endif

    // Map the logical read index (0 = oldest) onto the circular buffer
    assign w_oldest = (r_trig_ptr >= c_PRE) ? (r_trig_ptr - c_PRE) : (r_trig_ptr + c_WRAP);
    assign w_sum    = {1'b0, w_oldest} + {1'b0, rd_addr};
    assign w_raddr  = (w_sum >= c_DEPTH7) ? 6'(w_sum - c_DEPTH7) : 6'(w_sum);
    assign w_rzero  = (r_state != ST_DONE) || ({1'b0, rd_addr} >= c_DEPTH7);

    capture_ram #(
        .DEPTH (DEPTH),
        .WIDTH (CHANNELS)
    ) u_ram (
        .clk     (clk),
        .arstn   (arstn),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (w_sdata),
        .i_raddr (w_raddr),
        .i_rzero (w_rzero),
        .o_rdata (rd_data)
    );

    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_capture_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_capture_engine
// Description : Randomised self-checking bench for capture_engine. Expected
//               read-back comes from a list of every sample sent since start,
//               searched for the trigger by the edge rules, then windowed.
//               Timeout scenario is exercised when CAPTURE_TIMEOUT_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_capture_engine;

    localparam int CH      = 5;
    localparam int DEPTH   = 60;
    localparam int PRETRIG = 3;
    localparam int POSTLEN = DEPTH - PRETRIG - 1;

    logic          clk = 1'b0;
    logic          arstn;
    logic [CH:0]   logic_in;
    logic          start;
    logic          abort;
    logic [2:0]    trig_chan;
    logic [1:0]    trig_mode;
    logic [5:0]    rd_addr;
    logic [CH-1:0] rd_data;
    logic          busy;
    logic          done;
    logic          timed_out;

    int n_cmp = 0;
    int n_bad = 0;

    logic [CH-1:0] smp [$];

    always #5 clk = ~clk;

    capture_engine #(
        .CHANNELS (CH),
        .DEPTH    (DEPTH),
        .PRETRIG  (PRETRIG)
    ) dut (
        .clk       (clk),
        .arstn     (arstn),
        .logic_in  (logic_in),
        .start     (start),
        .abort     (abort),
        .trig_chan (trig_chan),
        .trig_mode (trig_mode),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .timed_out (timed_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One sample period: data with sample clock low, then sample clock high
    task automatic send_sample(input logic [CH-1:0] d);
        logic_in = {d, 1'b0};
        tick(3);
        logic_in[0] = 1'b1;
        tick(3);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    // Index of the first sample satisfying the trigger rule, or -1
    function automatic int find_trig(input logic [1:0] mode, input int chan);
        int   c;
        logic prev;
        logic cur;
        c    = (chan < CH) ? chan : 0;
        prev = 1'b0;
        for (int i = 0; i < smp.size(); i++) begin
            cur = smp[i][c];
            if (i >= PRETRIG) begin
                if (mode == 2'b11) return i;
                if (mode == 2'b00 && cur != prev) return i;
                if (mode == 2'b01 && cur && !prev) return i;
                if (mode == 2'b10 && !cur && prev) return i;
            end
            prev = cur;
        end
        return -1;
    endfunction

    task automatic check_readback(input int t);
        for (int k = 0; k < DEPTH; k++) begin
            rd_addr = 6'(k);
            tick(1);
            check($sformatf("rd[%0d]", k), 32'(rd_data), 32'(smp[t - PRETRIG + k]));
        end
        rd_addr = 6'(DEPTH);
        tick(1);
        check("rd_oob_depth", 32'(rd_data), 0);
        rd_addr = 6'd63;
        tick(1);
        check("rd_oob_63", 32'(rd_data), 0);
        rd_addr = 6'd0;
    endtask

    task automatic run_capture(input logic [1:0] mode, input logic [2:0] chan,
                               input int t, input bit mid_start);
        int total;
        total     = t + POSTLEN + 1;
        trig_mode = mode;
        trig_chan = chan;
        pulse_start();
        check("busy_on_start", 32'(busy), 1);
        check("done_on_start", 32'(done), 0);
        for (int i = 0; i < total; i++) begin
            if (i == total - 1) begin
                check("busy_before_last", 32'(busy), 1);
                check("done_before_last", 32'(done), 0);
            end
            send_sample(smp[i]);
            if (mid_start && i == PRETRIG + 1) pulse_start();
        end
        check("done_after_last", 32'(done), 1);
        check("busy_after_last", 32'(busy), 0);
        check_readback(t);
    endtask

    task automatic fill_counter(input int base, input int n);
        smp = {};
        for (int i = 0; i < n; i++) smp.push_back(CH'(base + i));
    endtask

    initial begin
        int            t;
        int            c;
        logic [1:0]    m;
        logic [CH-1:0] d;

        arstn     = 1'b0;
        logic_in  = '0;
        start     = 1'b0;
        abort     = 1'b0;
        trig_chan = '0;
        trig_mode = '0;
        rd_addr   = '0;
        tick(3);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_timed_out", 32'(timed_out), 0);
        check("rst_rd_data", 32'(rd_data), 0);
        arstn = 1'b1;
        tick(3);

        // Sample timing: ch1 = 0,0,0,0,1 with rising trigger on channel 0
        smp = {};
        for (int i = 0; i < DEPTH + 10; i++) begin
            d = CH'($urandom);
            if (i < 4) d[0] = 1'b0;
            else if (i == 4) d[0] = 1'b1;
            smp.push_back(d);
        end
        t = find_trig(2'b01, 0);
        run_capture(2'b01, 3'd0, t, 1'b0);

        // Sample count: immediate trigger with a counter pattern
        fill_counter(0, DEPTH + 5);
        run_capture(2'b11, 3'd1, find_trig(2'b11, 1), 1'b0);

        // Circular buffer: 200 ARMED samples before a falling trigger
        c = int'($urandom_range(0, CH - 1));
        smp = {};
        for (int i = 0; i < PRETRIG + 200 + 1 + POSTLEN; i++) begin
            d = CH'($urandom);
            d[c] = (i < PRETRIG + 200) ? 1'b1 : ((i == PRETRIG + 200) ? 1'b0 : d[c]);
            smp.push_back(d);
        end
        run_capture(2'b10, 3'(c), find_trig(2'b10, c), 1'b0);

        // Random modes and channels, including out-of-range channel indices
        for (int r = 0; r < 4; r++) begin
            m = 2'($urandom_range(0, 2));
            c = int'($urandom_range(0, 7));
            do begin
                smp = {};
                for (int i = 0; i < 300; i++) smp.push_back(CH'($urandom));
                t = find_trig(m, c);
            end while (t < 0 || t + POSTLEN + 1 > 300);
            run_capture(m, 3'(c), t, r == 1);
        end

        // Abort together with start while in POST
        fill_counter(7, DEPTH + 5);
        trig_mode = 2'b11;
        pulse_start();
        for (int i = 0; i < PRETRIG + 6; i++) send_sample(smp[i]);
        abort = 1'b1;
        start = 1'b1;
        tick(1);
        abort = 1'b0;
        start = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        send_sample(CH'($urandom));
        check("abort_stays_idle", 32'(busy), 0);
        fill_counter(11, DEPTH + 5);
        run_capture(2'b11, 3'd0, PRETRIG, 1'b0);

`ifdef CAPTURE_TIMEOUT_EN
        // Forced trigger after the ARMED dwell counter expires
        smp = {};
        for (int i = 0; i < PRETRIG + 2 + 1 + POSTLEN; i++) begin
            d = CH'($urandom);
            d[0] = 1'b0;
            smp.push_back(d);
        end
        trig_mode = 2'b01;
        trig_chan = 3'd0;
        pulse_start();
        check("tmo_cleared_on_start", 32'(timed_out), 0);
        for (int i = 0; i < PRETRIG + 2; i++) send_sample(smp[i]);
        tick(65600);
        check("tmo_still_armed", 32'(busy), 1);
        check("tmo_not_yet", 32'(timed_out), 0);
        send_sample(smp[PRETRIG + 2]);
        check("tmo_flag", 32'(timed_out), 1);
        check("tmo_busy", 32'(busy), 1);
        for (int i = 0; i < POSTLEN; i++) begin
            if (i == POSTLEN - 1) check("tmo_done_early", 32'(done), 0);
            send_sample(smp[PRETRIG + 3 + i]);
        end
        check("tmo_done", 32'(done), 1);
        check_readback(PRETRIG + 2);
`else
        // Without the timeout option ARMED waits on a static channel
        trig_mode = 2'b01;
        trig_chan = 3'd0;
        pulse_start();
        for (int i = 0; i < PRETRIG + 2; i++) send_sample(CH'(0));
        tick(300);
        check("static_busy", 32'(busy), 1);
        check("static_done", 32'(done), 0);
        check("static_timed_out", 32'(timed_out), 0);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("static_abort_busy", 32'(busy), 0);
`endif

        // Reset during POST with the sample clock held high
        fill_counter(3, DEPTH + 5);
        trig_mode = 2'b11;
        pulse_start();
        for (int i = 0; i < PRETRIG + 8; i++) send_sample(smp[i]);
        logic_in[0] = 1'b1;
        tick(1);
        arstn = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_done", 32'(done), 0);
        check("mid_rst_timed_out", 32'(timed_out), 0);
        check("mid_rst_rd_data", 32'(rd_data), 0);
        tick(2);
        arstn = 1'b1;
        tick(10);
        check("post_rst_busy", 32'(busy), 0);
        check("post_rst_done", 32'(done), 0);
        check("post_rst_rd_data", 32'(rd_data), 0);
        fill_counter(20, DEPTH + 5);
        run_capture(2'b11, 3'd2, PRETRIG, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/capture_engine.md
CAPTURE_ENGINE -- requirements
Module: capture_engine

Interface
REQ-001 Parameter CHANNELS, default 5: number of data channels captured.
REQ-002 Parameter DEPTH, default 60: samples per capture; max 64.
REQ-003 Parameter PRETRIG, default 3: samples retained before the trigger sample; 0 <= PRETRIG < DEPTH.
REQ-004 clk  input  1  system clock.
REQ-005 arstn  input  1  asynchronous, active-low reset.
REQ-006 logic_in  input  CHANNELS+1  asynchronous probe inputs; bit 0 is the external sample clock, bits CHANNELS:1 are data.
REQ-007 start  input  1  one-cycle pulse that arms a capture.
REQ-008 abort  input  1  one-cycle pulse that returns the block to IDLE.
REQ-009 trig_chan  input  3  data channel index used as trigger (0 selects logic_in[1]).
REQ-010 trig_mode  input  2  trigger edge: 00 any, 01 rising, 10 falling, 11 immediate.
REQ-011 rd_addr  input  6  read index; 0 is the oldest sample of the finished capture.
REQ-012 rd_data  output  CHANNELS  sample at rd_addr, registered.
REQ-013 busy  output  1  high in PRE, ARMED and POST.
REQ-014 done  output  1  high in DONE; buffer is stable and readable.
REQ-015 timed_out  output  1  high when the last capture was force-triggered.

Function
REQ-016 All logic_in bits SHALL pass through a 2-flop synchronizer on clk; no logic SHALL be clocked by logic_in[0].
REQ-017 A sample event SHALL occur on the clk cycle after the synchronized logic_in[0] rises (0->1).
REQ-018 States: IDLE, PRE, ARMED, POST, DONE.
REQ-019 IDLE->PRE on start; write pointer and sample count clear.
REQ-020 PRE: each sample event writes the data channels at wr_ptr and increments wr_ptr modulo DEPTH; PRE->ARMED once PRETRIG samples are written (immediately if PRETRIG=0).
REQ-021 ARMED: samples continue to be written circularly; the trigger is evaluated on each sample event against the previous sample of trig_chan.
REQ-022 The trigger sample SHALL be written, recorded as trig_ptr, and cause ARMED->POST.
REQ-023 trig_mode 11 SHALL trigger on the first ARMED sample event.
REQ-024 POST: the block SHALL write DEPTH-PRETRIG-1 further samples, then enter DONE.
REQ-025 DONE: oldest sample index = (trig_ptr - PRETRIG) mod DEPTH; rd_data is valid 1 clk after rd_addr changes; rd_addr >= DEPTH returns 0.
REQ-026 DONE->PRE on start (re-arm); done drops in the same cycle busy rises.
REQ-027 abort from any state -> IDLE the next cycle; the buffer contents are undefined.
REQ-028 abort and start in the same cycle: abort wins.
REQ-029 start while busy SHALL be ignored.
REQ-030 A trig_chan value >= CHANNELS SHALL be treated as 0.

Reset
REQ-031 arstn low SHALL force the state to IDLE, wr_ptr/trig_ptr/count to 0, busy=0, done=0, timed_out=0, rd_data=0, and synchronizer flops to 0.
REQ-032 Reset mid-capture SHALL discard the capture; no spurious sample event SHALL occur on reset release, even if logic_in[0] is high.

Configuration
REQ-033 With CAPTURE_TIMEOUT_EN defined: a 16-bit clk counter runs in ARMED; on reaching 0xFFFF without a trigger, the next sample event is taken as the trigger and timed_out is set (cleared on start).
REQ-034 Without CAPTURE_TIMEOUT_EN: ARMED waits indefinitely and timed_out is tied to 0.

Structure
REQ-035 Shared package capture_pkg SHALL hold the state enum, the trig_mode encodings, and the timeout constant 16'hFFFF.
REQ-036 The sample memory SHALL be a sub-module capture_ram (DEPTH x CHANNELS, 1 write port, registered read port).

Verification
REQ-037 Check the sample timing: PRETRIG=3, trig_mode=01, trig_chan=0; ch1 = 0,0,0,0,1,... -> done; rd_addr 3 holds the first 1 on ch1; rd_addr 0-2 are 0.
REQ-038 Check the sample count: trig_mode=11 with 60 sample clocks of a counter pattern -> exactly 60 sequential values are read back at rd_addr 0..59.
REQ-039 Check the circular buffer: 200 samples in ARMED before a falling trigger -> the oldest sample equals the 3 samples preceding the trigger, and no data is lost at the wrap.
REQ-040 Check the control priority: abort asserted in POST together with start -> IDLE, busy=0, done=0; a later start produces a full capture.
REQ-041 Check the timeout: with CAPTURE_TIMEOUT_EN and a static trigger channel, after 65535 clks plus one sample event -> POST, timed_out=1, and done follows after 56 more samples.
REQ-042 Check reset: arstn asserted during POST with logic_in[0]=1, then released -> IDLE, all outputs 0, and no write until a new start followed by a rising sample clock.
